bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter that sits directly downstream of the lab counter. It takes the `count` word and produces packed BCD digits for the seven-segment display decoder. It uses the shift-and-add-3 (double-dabble) algorithm, one bit per clock, so it needs one adjust stage per digit instead of a wide combinational divider. A start/valid handshake lets the top level sample the counter at any rate.

---
 rtl/bcd_pkg.sv | 31 +++
 rtl/bcd_digit_adj.sv | 17 +
 rtl/bin2bcd_seq.sv | 138 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the sequential binary-to-BCD converter
package bcd_pkg;

    // Legacy-compatible state encodings; the enum below is built on them.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT
    } bcd_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
    localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;

    // True when DIGITS decimal digits can hold every WIDTH-bit value,
    // i.e. 10^digits > 2^width - 1.
    function automatic bit bcd_params_ok(input int width, input int digits);
        longint lim;
        longint max_bin;
        lim = 1;
        for (int i = 0; i < digits; i++) begin
            lim = lim * 10;
        end
        max_bin = (longint'(1) << width) - 1;
        return (lim > max_bin);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - combinational add-3 adjust for one BCD digit
//
// Ports:
//   i_digit  in  4 : working BCD digit before the shift
//   o_digit  out 4 : i_digit + 3 when i_digit >= 5, else i_digit
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t i_digit,
    output bcd_digit_t o_digit
);

    // No carry into the next digit: a digit never exceeds 9 before the
    // adjust, so the 4-bit sum stays below 16.
    assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? (i_digit + BCD_ADJ_ADD) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter, one bit per clock
//
// Optional feature macro: BIN2BCD_BLANK_EN (registered leading-zero blank mask).
//
// Ports:
//   clk    in  1          : clock
//   rst    in  1          : synchronous active-high reset
//   start  in  1          : conversion request, sampled only while idle
//   bin    in  WIDTH      : value to convert, captured with start
//   busy   out 1          : conversion in progress
//   valid  out 1          : one-cycle pulse, bcd/blank just updated
//   bcd    out 4*DIGITS   : packed BCD result, digit 0 in [3:0]
//   blank  out DIGITS     : leading-zero blank mask (all zero without the macro)
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    generate
        if (!bcd_params_ok(WIDTH, DIGITS)) begin : g_param_check
            $error("bin2bcd_seq: DIGITS too small for WIDTH");
        end
    endgenerate

    bcd_state_t         r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_bin;
    logic [BW-1:0]      r_work;
    logic [BW-1:0]      r_bcd;
    logic               r_valid;

    logic [BW-1:0]          w_adj;
    logic [BW+WIDTH-1:0]    w_cat;
    logic [BW-1:0]          w_work_next;
    logic [WIDTH-1:0]       w_bin_next;
    logic                   w_last;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .i_digit (r_work[4*gi +: 4]),
                .o_digit (w_adj[4*gi +: 4])
            );
        end
    endgenerate

    // Adjusted digits and remaining binary bits shift as one long register;
    // the binary MSB enters the BCD LSB.
    assign w_cat       = {w_adj, r_bin} << 1;
    assign w_work_next = w_cat[BW+WIDTH-1:WIDTH];
    assign w_bin_next  = w_cat[WIDTH-1:0];
    assign w_last      = (r_cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bin   <= '0;
            r_work  <= '0;
            r_bcd   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin   <= bin;
                        r_work  <= '0;
                        r_cnt   <= CW'(WIDTH);
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_work <= w_work_next;
                    r_bin  <= w_bin_next;
                    r_cnt  <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_bcd   <= w_work_next;
                        r_valid <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy  = (r_state == SHIFT);
    assign valid = r_valid;
    assign bcd   = r_bcd;

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] r_blank;
    logic [DIGITS-1:0] w_blank_next;

    // Walk from the top digit down; a digit is blanked while every digit
    // at or above it is zero. Digit 0 always stays visible.
    always_comb begin : p_blank
        logic v_zero_run;
        w_blank_next = '0;
        v_zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (w_work_next[4*i +: 4] != 4'd0) begin
                v_zero_run = 1'b0;
            end
            w_blank_next[i] = v_zero_run;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blank <= '0;
        end else if ((r_state == SHIFT) && w_last) begin
            r_blank <= w_blank_next;
        end
    end

    assign blank = r_blank;
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        valid;
    logic [11:0] bcd;
    logic [2:0]  blank;

    int total = 0;
    int bad   = 0;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .valid (valid),
        .bcd   (bcd),
        .blank (blank)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ref_bcd(input int v);
        logic [11:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [2:0] ref_blank(input int v);
        logic [2:0] b;
        int p;
        b = '0;
        p = 1;
`ifdef BIN2BCD_BLANK_EN
        for (int i = 1; i < DIGITS; i++) begin
            p = p * 10;
            b[i] = (v < p);
        end
`endif
        return b;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!valid && n < 40);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; bin = '0;
        tick(); tick();
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (valid !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
        total++; if (bcd !== 12'h000) begin bad++; $display("FAIL reset_bcd got=%h exp=000", bcd); end
        total++; if (blank !== 3'b000) begin bad++; $display("FAIL reset_blank got=%b exp=000", blank); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zero;
        int n;
        start = 1'b1; bin = 8'd0;
        tick();
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy got=%b exp=1", busy); end
        wait_valid(n);
        total++; if (valid !== 1'b1 || n != WIDTH) begin bad++; $display("FAIL zero_latency got=%0d exp=%0d", n, WIDTH); end
        total++; if (bcd !== ref_bcd(0)) begin bad++; $display("FAIL zero_bcd got=%h exp=%h", bcd, ref_bcd(0)); end
        total++; if (blank !== ref_blank(0)) begin bad++; $display("FAIL zero_blank got=%b exp=%b", blank, ref_blank(0)); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_fall got=%b exp=0", busy); end
        tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL zero_valid_single got=%b exp=0", valid); end
    endtask

    task automatic test_sweep;
        int n;
        start = 1'b1; bin = 8'd0;
        tick();
        start = 1'b0;
        for (int v = 0; v < 256; v++) begin
            wait_valid(n);
            total++;
            if (!valid || n != WIDTH) begin
                bad++; $display("FAIL sweep_latency v=%0d got=%0d exp=%0d", v, n, WIDTH);
                return;
            end
            total++; if (bcd !== ref_bcd(v)) begin bad++; $display("FAIL sweep_bcd v=%0d got=%h exp=%h", v, bcd, ref_bcd(v)); end
            total++; if (blank !== ref_blank(v)) begin bad++; $display("FAIL sweep_blank v=%0d got=%b exp=%b", v, blank, ref_blank(v)); end
            if (v < 255) begin
                start = 1'b1; bin = 8'(v + 1);
                tick();
                start = 1'b0;
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL sweep_b2b_busy v=%0d got=%b exp=1", v + 1, busy); end
            end else begin
                tick();
            end
        end
    endtask

    task automatic test_random;
        int v, n, gap;
        for (int k = 0; k < 20; k++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            v = $urandom_range(0, 255);
            start = 1'b1; bin = 8'(v);
            tick();
            n = 0;
            while (!valid && n < 40) begin
                start = 1'(($urandom % 2));
                bin = 8'($urandom);
                tick();
                n++;
            end
            start = 1'b0;
            total++; if (!valid || n != WIDTH) begin bad++; $display("FAIL rand_latency v=%0d got=%0d exp=%0d", v, n, WIDTH); end
            total++; if (bcd !== ref_bcd(v)) begin bad++; $display("FAIL rand_bcd v=%0d got=%h exp=%h", v, bcd, ref_bcd(v)); end
            total++; if (blank !== ref_blank(v)) begin bad++; $display("FAIL rand_blank v=%0d got=%b exp=%b", v, blank, ref_blank(v)); end
            tick();
        end
        v = 7;
        start = 1'b1; bin = 8'(v);
        tick();
        start = 1'b0;
        wait_valid(n);
        total++; if (bcd !== 12'h007) begin bad++; $display("FAIL seven_bcd got=%h exp=007", bcd); end
        total++; if (blank !== ref_blank(v)) begin bad++; $display("FAIL seven_blank got=%b exp=%b", blank, ref_blank(v)); end
        tick();
    endtask

    task automatic test_ignore_start;
        int pulses;
        int consec;
        logic prev;
        start = 1'b1; bin = 8'd42;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; bin = 8'd99;
        tick();
        start = 1'b0; bin = 8'd0;
        pulses = 0; consec = 0; prev = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (valid) pulses++;
            if (valid && prev) consec++;
            prev = valid;
            tick();
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL ignore_pulses got=%0d exp=1", pulses); end
        total++; if (consec != 0) begin bad++; $display("FAIL ignore_consec got=%0d exp=0", consec); end
        total++; if (bcd !== 12'h042) begin bad++; $display("FAIL ignore_bcd got=%h exp=042", bcd); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_idle got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid;
        int pulses, n;
        start = 1'b1; bin = 8'd200;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        total++; if (valid !== 1'b0)   begin bad++; $display("FAIL rstmid_valid got=%b exp=0", valid); end
        total++; if (bcd !== 12'h000)  begin bad++; $display("FAIL rstmid_bcd got=%h exp=000", bcd); end
        total++; if (blank !== 3'b000) begin bad++; $display("FAIL rstmid_blank got=%b exp=000", blank); end
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            if (valid) pulses++;
            tick();
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL rstmid_no_valid got=%0d exp=0", pulses); end
        start = 1'b1; bin = 8'd200;
        tick();
        start = 1'b0;
        wait_valid(n);
        total++; if (!valid || n != WIDTH) begin bad++; $display("FAIL rstmid_latency got=%0d exp=%0d", n, WIDTH); end
        total++; if (bcd !== 12'h200) begin bad++; $display("FAIL rstmid_bcd2 got=%h exp=200", bcd); end
        tick();
    endtask

    task automatic test_counter;
        int q[$];
        int cnt, exp_v, last_cyc, valids;
        cnt = 0; last_cyc = -1; valids = 0;
        bin = 8'(cnt);
        start = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (!busy) q.push_back(cnt);
            tick();
            cnt = (cnt + 1) % 256;
            bin = 8'(cnt);
            if (valid) begin
                valids++;
                exp_v = (q.size() > 0) ? q.pop_front() : -1;
                total++; if (bcd !== ref_bcd(exp_v)) begin bad++; $display("FAIL counter_bcd got=%h exp=%h", bcd, ref_bcd(exp_v)); end
                if (last_cyc >= 0) begin
                    total++; if (c - last_cyc != WIDTH + 1) begin bad++; $display("FAIL counter_spacing got=%0d exp=%0d", c - last_cyc, WIDTH + 1); end
                end
                last_cyc = c;
            end
        end
        start = 1'b0;
        total++; if (valids < 20) begin bad++; $display("FAIL counter_count got=%0d exp>=20", valids); end
        for (int c = 0; c < 12; c++) tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bin = '0;
        test_reset();
        test_zero();
        test_sweep();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_counter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
